// File: rtl/pie_encoder.sv
// PIE downlink encoder: serialises a command bit stream into the reader-to-tag
// baseband envelope, prefixed with a preamble or frame-sync.
module pie_encoder #(
  parameter int COUNT_WIDTH = 15,
  parameter int TARI        = 25,
  parameter int DATA1       = 50,
  parameter int PW          = 12,
  parameter int DELIM       = 12,
  parameter int TRCAL       = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic preamble_sel,
  input  logic in_dat,
  input  logic in_vld,
  input  logic in_last,
  output logic in_rdy,
  output logic out_dat,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int RTCAL = TARI + DATA1;

  localparam logic [COUNT_WIDTH-1:0] LEN_DELIM = COUNT_WIDTH'(DELIM);
  localparam logic [COUNT_WIDTH-1:0] LEN_TARI  = COUNT_WIDTH'(TARI);
  localparam logic [COUNT_WIDTH-1:0] LEN_DATA1 = COUNT_WIDTH'(DATA1);
  localparam logic [COUNT_WIDTH-1:0] LEN_RTCAL = COUNT_WIDTH'(RTCAL);
  localparam logic [COUNT_WIDTH-1:0] LEN_TRCAL = COUNT_WIDTH'(TRCAL);
  localparam logic [COUNT_WIDTH-1:0] LEN_PW    = COUNT_WIDTH'(PW);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELIM, S_DATA0, S_RTCAL, S_TRCAL, S_BITS
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pre_q, pre_d;
  logic                   buf_vld_q, buf_vld_d;
  logic                   buf_dat_q, buf_dat_d;
  logic                   buf_last_q, buf_last_d;
  logic                   cur_last_q, cur_last_d;
  logic                   done_q, done_d;
  logic                   underrun_q, underrun_d;

  logic bound;
  logic enter_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pre_q      <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_dat_q  <= 1'b0;
      buf_last_q <= 1'b0;
      cur_last_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      buf_vld_q  <= buf_vld_d;
      buf_dat_q  <= buf_dat_d;
      buf_last_q <= buf_last_d;
      cur_last_q <= cur_last_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    buf_vld_d  = buf_vld_q;
    buf_dat_d  = buf_dat_q;
    buf_last_d = buf_last_q;
    cur_last_d = cur_last_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    enter_bit  = 1'b0;
    bound      = (cnt_q == CNT_ONE);

    if (in_vld && in_rdy) begin
      buf_vld_d  = 1'b1;
      buf_dat_d  = in_dat;
      buf_last_d = in_last;
    end

    if (state_q != S_IDLE) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DELIM;
          cnt_d   = LEN_DELIM;
          pre_d   = preamble_sel;
        end
      end
      S_DELIM: if (bound) begin
        state_d = S_DATA0;
        cnt_d   = LEN_TARI;
      end
      S_DATA0: if (bound) begin
        state_d = S_RTCAL;
        cnt_d   = LEN_RTCAL;
      end
      S_RTCAL: if (bound) begin
        if (pre_q) begin
          state_d = S_TRCAL;
          cnt_d   = LEN_TRCAL;
        end else begin
          enter_bit = 1'b1;
        end
      end
      S_TRCAL: if (bound) enter_bit = 1'b1;
      S_BITS: if (bound) begin
        if (cur_last_q) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          buf_vld_d = 1'b0;
        end else begin
          enter_bit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An empty buffer at a bit-symbol entry aborts the frame.
    if (enter_bit) begin
      if (buf_vld_q) begin
        state_d    = S_BITS;
        cur_last_d = buf_last_q;
        buf_vld_d  = 1'b0;
        cnt_d      = buf_dat_q ? LEN_DATA1 : LEN_TARI;
      end else begin
        state_d    = S_IDLE;
        underrun_d = 1'b1;
        buf_vld_d  = 1'b0;
      end
    end
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    in_rdy   = busy && !buf_vld_q;
    out_dat  = (state_q == S_IDLE) || ((state_q != S_DELIM) && (cnt_q > LEN_PW));
    done     = done_q;
    underrun = underrun_q;
  end

endmodule

// File: tb/tb_pie_encoder.sv
// Scoreboard bench for pie_encoder: the driver queues expected envelope runs
// per frame; a negedge monitor run-length encodes out_dat and compares.
module tb_pie_encoder;

  localparam int TARI  = 25;
  localparam int DATA1 = 50;
  localparam int PW    = 12;
  localparam int DELIM = 12;
  localparam int TRCAL = 200;
  localparam int RTCAL = TARI + DATA1;

  logic clk = 1'b0;
  logic rst, start, preamble_sel, in_dat, in_vld, in_last;
  logic in_rdy, out_dat, busy, done, underrun;

  typedef struct { int lvl; int len; } run_t;
  typedef struct { int blen; int dn; int ur; } end_t;

  run_t exp_runs[$];
  end_t exp_ends[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_ignore = 1'b0;

  pie_encoder #(
    .COUNT_WIDTH(15), .TARI(TARI), .DATA1(DATA1),
    .PW(PW), .DELIM(DELIM), .TRCAL(TRCAL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .preamble_sel(preamble_sel),
    .in_dat(in_dat), .in_vld(in_vld), .in_last(in_last),
    .in_rdy(in_rdy), .out_dat(out_dat), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_sym(input int len);
    exp_runs.push_back('{1, len - PW});
    exp_runs.push_back('{0, PW});
  endtask

  task automatic exp_frame(input bit pre, input int n, input bit [7:0] bits, input bit aborted);
    int total;
    exp_runs.push_back('{0, DELIM});
    exp_sym(TARI);
    exp_sym(RTCAL);
    total = DELIM + TARI + RTCAL;
    if (pre) begin
      exp_sym(TRCAL);
      total += TRCAL;
    end
    for (int i = 0; i < n; i++) begin
      exp_sym(bits[i] ? DATA1 : TARI);
      total += bits[i] ? DATA1 : TARI;
    end
    exp_ends.push_back('{total, aborted ? 0 : 1, aborted ? 1 : 0});
  endtask

  // Monitor
  bit in_frame = 1'b0;
  bit chk_done_low = 1'b0;
  int cur_lvl, run_len, blen;

  task automatic emit(input int lvl, input int len);
    run_t r;
    if (exp_runs.size() == 0) begin
      check("unexpected_run", 1, 0);
    end else begin
      r = exp_runs.pop_front();
      check("run_level", lvl, r.lvl);
      check("run_length", len, r.len);
    end
  endtask

  always @(negedge clk) begin
    if (rst || mon_ignore) begin
      in_frame     = 1'b0;
      chk_done_low = 1'b0;
    end else begin
      if (chk_done_low) begin
        check("done_one_cycle", int'(done), 0);
        chk_done_low = 1'b0;
      end
      if (busy) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur_lvl  = 0;
          run_len  = 0;
          blen     = 0;
        end
        blen++;
        if (int'(out_dat) == cur_lvl) run_len++;
        else begin
          emit(cur_lvl, run_len);
          cur_lvl = int'(out_dat);
          run_len = 1;
        end
      end else if (in_frame) begin
        end_t e;
        emit(cur_lvl, run_len);
        in_frame = 1'b0;
        if (exp_ends.size() == 0) begin
          check("unexpected_frame_end", 1, 0);
        end else begin
          e = exp_ends.pop_front();
          check("busy_length", blen, e.blen);
          check("done_at_end", int'(done), e.dn);
          check("underrun_at_end", int'(underrun), e.ur);
          check("out_dat_idle", int'(out_dat), 1);
        end
        chk_done_low = 1'b1;
      end
    end
  end

  // Driver helpers (all called at a negedge)
  task automatic start_frame(input bit pre);
    start = 1'b1;
    preamble_sel = pre;
    @(negedge clk);
    start = 1'b0;
    preamble_sel = 1'b0;
  endtask

  task automatic push_bit(input bit b, input bit l);
    int t = 0;
    in_vld = 1'b1; in_dat = b; in_last = l;
    while (!in_rdy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("push_timeout", int'(t < 2000), 1);
    @(negedge clk);
    check("rdy_drop_after_push", int'(in_rdy), 0);
    in_vld = 1'b0; in_dat = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("frame_end_timeout", int'(t < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", int'(t < 5000), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; preamble_sel = 1'b0;
    in_dat = 1'b0; in_vld = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_dat", int'(out_dat), 1);
    check("rst_in_rdy", int'(in_rdy), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame-sync 1,0,1 with a stray start mid-frame
    exp_frame(1'b0, 3, 8'b101, 1'b0);
    start_frame(1'b0);
    check("rdy_after_start", int'(in_rdy), 1);
    push_bit(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    start_frame(1'b1);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b1);
    wait_end();

    // Preamble 1,0,1
    exp_frame(1'b1, 3, 8'b101, 1'b0);
    start_frame(1'b1);
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b1);
    wait_end();

    // Underrun after one bit
    exp_frame(1'b0, 1, 8'b1, 1'b1);
    start_frame(1'b0);
    push_bit(1'b1, 1'b0);
    wait_end();
    for (int i = 0; i < 10; i++) begin
      check("post_underrun_out_dat", int'(out_dat), 1);
      check("post_underrun_done", int'(done), 0);
      @(negedge clk);
    end

    // Bits offered while idle are refused
    in_vld = 1'b1; in_dat = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_rdy_low", int'(in_rdy), 0);
    end
    in_vld = 1'b0; in_dat = 1'b0; in_last = 1'b0;

    // Single bit 0 with last, then back-to-back frame started on done
    exp_frame(1'b0, 1, 8'b0, 1'b0);
    start_frame(1'b0);
    push_bit(1'b0, 1'b1);
    wait_done();
    exp_frame(1'b0, 2, 8'b10, 1'b0);
    start_frame(1'b0);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b1);
    wait_end();

    // Reset during the low phase of RTcal
    mon_ignore = 1'b1;
    start_frame(1'b0);
    push_bit(1'b1, 1'b1);
    repeat (DELIM + TARI + RTCAL - PW + 3) @(negedge clk);
    check("rtcal_low_before_rst", int'(out_dat), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_dat", int'(out_dat), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_in_rdy", int'(in_rdy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_ignore = 1'b0;
    @(negedge clk);

    exp_frame(1'b0, 2, 8'b10, 1'b0);
    start_frame(1'b0);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b1);
    wait_end();

    check("runs_left", exp_runs.size(), 0);
    check("ends_left", exp_ends.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
